// File: rtl/stack_unit_pkg.sv
// Shared definitions for the data stack: FSM state encoding, default
// sizing, and the stack-pointer width helper.
package stack_unit_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH = 64;

    typedef enum logic [1:0] {
        STK_IDLE,
        STK_WAIT,
        STK_BUBBLE
    } stack_state_t;

    // The stack pointer must represent 0..DEPTH inclusive, hence one extra bit.
    function automatic int unsigned sp_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/stack_unit_if.sv
// Decode-side interface of the data stack: push/pop requests in, popped data,
// bubble/stall handshake and status flags out.
interface stack_unit_if #(
    parameter int unsigned WIDTH = 8
);

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] push_data;
    logic [WIDTH-1:0] pop_data;
    logic             pop_bubble;
    logic             stall;
    logic             full;
    logic             empty;
    logic             overflow_err;
    logic             underflow_err;
    logic             protocol_err;

    // Decoder side: issues PSH/POP and consumes the popped value.
    modport master (
        output push, pop, push_data,
        input  pop_data, pop_bubble, stall, full, empty,
        input  overflow_err, underflow_err, protocol_err
    );

    // Stack side.
    modport slave (
        input  push, pop, push_data,
        output pop_data, pop_bubble, stall, full, empty,
        output overflow_err, underflow_err, protocol_err
    );

endinterface

// File: rtl/stack_ram.sv
// Single-port stack storage: synchronous write, registered read.
// Contents are not reset; only entries below sp are ever read back.
module stack_ram #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write on we; the read data register updates every cycle from addr.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/stack_unit.sv
// Data stack backing PSH/POP. A pop reads the synchronous RAM, so the value
// reaches pop_data two cycles after the request; fetch/decode is stalled for
// that gap and pop_bubble pulses for one cycle when pop_data is valid.
module stack_unit
    import stack_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    stack_unit_if.slave bus
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned SPW = sp_width(DEPTH);
    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

    stack_state_t     state, state_n;
    logic [SPW-1:0]   sp, sp_n, sp_dec;
    logic             zero_pending, zero_pending_n;
    logic [WIDTH-1:0] pop_data_q, pop_data_n;
    logic             ovf_q, ovf_n;
    logic             unf_q, unf_n;
    logic             prot_q, prot_n;

    logic             ram_we;
    logic [AW-1:0]    ram_addr;
    logic [WIDTH-1:0] ram_dout;

    stack_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (bus.push_data),
        .dout (ram_dout)
    );

    // State, stack pointer, pop data and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= STK_IDLE;
            sp           <= '0;
            zero_pending <= 1'b0;
            pop_data_q   <= '0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
            prot_q       <= 1'b0;
        end else begin
            state        <= state_n;
            sp           <= sp_n;
            zero_pending <= zero_pending_n;
            pop_data_q   <= pop_data_n;
            ovf_q        <= ovf_n;
            unf_q        <= unf_n;
            prot_q       <= prot_n;
        end
    end

    // Next-state logic: requests are only looked at in IDLE; pop wins over push.
    always_comb begin
        state_n        = state;
        sp_n           = sp;
        zero_pending_n = zero_pending;
        pop_data_n     = pop_data_q;
        ovf_n          = ovf_q;
        unf_n          = unf_q;
        prot_n         = prot_q;
        ram_we         = 1'b0;
        sp_dec         = sp - SPW'(1);
        ram_addr       = sp[AW-1:0];

        case (state)
            STK_IDLE: begin
                if (bus.pop) begin
                    if (bus.push) begin
                        prot_n = 1'b1;
                    end
                    if (sp == '0) begin
                        unf_n          = 1'b1;
                        zero_pending_n = 1'b1;
                    end else begin
                        ram_addr = sp_dec[AW-1:0];
                        sp_n     = sp_dec;
                    end
                    state_n = STK_WAIT;
                end else if (bus.push) begin
                    if (sp == SP_FULL) begin
                        ovf_n = 1'b1;
                    end else begin
                        ram_we = 1'b1;
                        sp_n   = sp + SPW'(1);
                    end
                end
            end
            STK_WAIT: begin
                pop_data_n = zero_pending ? '0 : ram_dout;
                state_n    = STK_BUBBLE;
            end
            STK_BUBBLE: begin
                zero_pending_n = 1'b0;
                state_n        = STK_IDLE;
            end
            default: begin
                state_n = STK_IDLE;
            end
        endcase
    end

    // Output decode from registered state only; no input-to-output paths.
    always_comb begin
        bus.stall         = (state != STK_IDLE);
        bus.pop_bubble    = (state == STK_BUBBLE);
        bus.full          = (sp == SP_FULL);
        bus.empty         = (sp == '0);
        bus.pop_data      = pop_data_q;
        bus.overflow_err  = ovf_q;
        bus.underflow_err = unf_q;
        bus.protocol_err  = prot_q;
    end

endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit (DEPTH=4 so the full boundary is reachable).
// Expected pop values go into a queue when a pop is issued; a negedge monitor
// pops and compares them whenever pop_bubble is seen.
module tb_stack_unit;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [WIDTH-1:0] exp_q [$];

    stack_unit_if #(.WIDTH(WIDTH)) bus ();

    stack_unit #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every bubble must match the oldest expected value.
    always @(negedge clk) begin
        if (!reset && bus.pop_bubble) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL bubble_unexpected: got pop_bubble with pop_data=%h, expected none", bus.pop_data);
            end else begin
                logic [WIDTH-1:0] e;
                e = exp_q.pop_front();
                if (bus.pop_data !== e) begin
                    n_bad++;
                    $display("FAIL pop_data: got %h expected %h", bus.pop_data, e);
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        bus.push = 1'b0;
        bus.pop = 1'b0;
        bus.push_data = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic push_val(input logic [WIDTH-1:0] v);
        bus.push = 1'b1;
        bus.push_data = v;
        @(posedge clk);
        #1 bus.push = 1'b0;
    endtask

    // Issue one pop, check stall during the gap and a latency of exactly 2.
    task automatic pop_once(input logic [WIDTH-1:0] e, input string name);
        int lat;
        lat = 0;
        exp_q.push_back(e);
        bus.pop = 1'b1;
        @(posedge clk);
        #1 bus.pop = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.stall !== 1'b1) begin
                n_bad++;
                $display("FAIL %s_stall: cycle %0d stall=%b expected 1", name, k, bus.stall);
            end
            if (bus.pop_bubble === 1'b1) begin
                lat = k;
                break;
            end
        end
        n_cmp++;
        if (lat != 2) begin
            n_bad++;
            $display("FAIL %s_latency: got %0d expected 2", name, lat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bus.empty, bus.full, bus.stall, bus.pop_bubble, bus.pop_data,
             bus.overflow_err, bus.underflow_err, bus.protocol_err} !== {4'b1000, 8'h00, 3'b000}) begin
            n_bad++;
            $display("FAIL reset_state: empty=%b full=%b stall=%b bubble=%b data=%h errs=%b%b%b expected 1 0 0 0 00 000",
                     bus.empty, bus.full, bus.stall, bus.pop_bubble, bus.pop_data,
                     bus.overflow_err, bus.underflow_err, bus.protocol_err);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_push_pop();
        int bub [$];
        push_val(8'h11);
        push_val(8'h22);
        push_val(8'h33);
        pop_once(8'h33, "pop1");
        push_val(8'h33);
        // Hold pop high: accepted pops should land every 3 cycles.
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h11);
        bus.pop = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1 if (c == 7) bus.pop = 1'b0;
            @(negedge clk);
            if (bus.pop_bubble === 1'b1) bub.push_back(c);
        end
        n_cmp++;
        if (bub.size() != 3 || bub[0] != 2 || bub[1] != 5 || bub[2] != 8) begin
            n_bad++;
            $display("FAIL b2b_spacing: %0d bubbles, first at %0d, expected 3 at cycles 2,5,8",
                     bub.size(), (bub.size() > 0) ? bub[0] : -1);
        end
        n_cmp++;
        if (bus.empty !== 1'b1 || bus.underflow_err !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_empty: empty=%b underflow=%b expected 1 0", bus.empty, bus.underflow_err);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_overflow();
        logic [WIDTH-1:0] v [5];
        do_reset();
        v = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        for (int i = 0; i < 5; i++) begin
            push_val(v[i]);
            @(negedge clk);
            if (i == 3) begin
                n_cmp++;
                if (bus.full !== 1'b1 || bus.overflow_err !== 1'b0) begin
                    n_bad++;
                    $display("FAIL full_after_4: full=%b ovf=%b expected 1 0", bus.full, bus.overflow_err);
                end
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (bus.full !== 1'b1 || bus.overflow_err !== 1'b1) begin
            n_bad++;
            $display("FAIL overflow: full=%b ovf=%b expected 1 1", bus.full, bus.overflow_err);
        end
        pop_once(8'hA4, "ovf_pop");
        pop_once(8'hA3, "ovf_pop");
        pop_once(8'hA2, "ovf_pop");
        pop_once(8'hA1, "ovf_pop");
        @(negedge clk);
        n_cmp++;
        if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_drain: empty=%b full=%b expected 1 0", bus.empty, bus.full);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_underflow();
        do_reset();
        pop_once(8'h00, "unf_pop");
        @(negedge clk);
        n_cmp++;
        if (bus.underflow_err !== 1'b1 || bus.empty !== 1'b1 || bus.overflow_err !== 1'b0) begin
            n_bad++;
            $display("FAIL underflow: unf=%b empty=%b ovf=%b expected 1 1 0",
                     bus.underflow_err, bus.empty, bus.overflow_err);
        end
        // sp stayed 0: a push then pop must return the pushed value.
        @(posedge clk);
        #1;
        push_val(8'h5C);
        pop_once(8'h5C, "unf_recover");
    endtask

    task automatic test_protocol();
        do_reset();
        push_val(8'hAA);
        exp_q.push_back(8'hAA);
        bus.push = 1'b1;
        bus.pop = 1'b1;
        bus.push_data = 8'hBB;
        @(posedge clk);
        #1;
        bus.pop = 1'b0;
        bus.push_data = 8'hCC;   // push held through the stall window
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 bus.push = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.protocol_err !== 1'b1 || bus.empty !== 1'b1 || bus.overflow_err !== 1'b0) begin
            n_bad++;
            $display("FAIL protocol: prot=%b empty=%b ovf=%b expected 1 1 0",
                     bus.protocol_err, bus.empty, bus.overflow_err);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_pop();
        int seen;
        seen = 0;
        do_reset();
        push_val(8'h77);
        bus.pop = 1'b1;
        @(posedge clk);
        #1 bus.pop = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.stall !== 1'b0 || bus.pop_bubble !== 1'b0 || bus.empty !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_pop: stall=%b bubble=%b empty=%b expected 0 0 1",
                     bus.stall, bus.pop_bubble, bus.empty);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.pop_bubble === 1'b1) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL reset_no_bubble: got %0d bubbles expected 0", seen);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_overflow();
        test_underflow();
        test_protocol();
        test_reset_mid_pop();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL missing_bubbles: %0d expected pops never appeared, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
